branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined RV32I core. Replaces the static "predict not-taken, resolve in EX" fetch path.
- IF stage: looks up the current PC in a tagged, direct-mapped BTB and a 2-bit-counter BHT (bimodal or gshare) in the same cycle, and returns a predicted next PC.
- EX stage: supplies the resolved outcome. The block trains its tables, flags mispredicts with a redirect PC, and keeps saturating performance counters.

Parameters:
- BTB_ENTRIES, 16: BTB entries; power of 2, ≥2.
- BHT_ENTRIES, 64: 2-bit counters; power of 2, ≥2.
- GHR_W, 6: global history bits; 1 ≤ GHR_W ≤ log2(BHT_ENTRIES).
- MODE, 1: 0 = bimodal (index from PC only); 1 = gshare (PC index XOR GHR).
- CNT_W, 32: width of each performance counter.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset.
- if_pc, input, 32: PC being fetched.
- pred_taken, output, 1: predict taken.
- pred_target, output, 32: predicted next PC.
- ex_valid, input, 1: EX holds a valid instruction this cycle.
- ex_pc, input, 32: PC of the EX instruction.
- ex_is_branch, input, 1: conditional branch.
- ex_is_jump, input, 1: JAL or JALR.
- ex_taken, input, 1: resolved taken (1 for jumps).
- ex_target, input, 32: resolved target address.
- ex_pred_taken, input, 1: pred_taken value piped from IF with this instruction.
- ex_pred_target, input, 32: pred_target value piped from IF with this instruction.
- ex_mispredict, output, 1: redirect required.
- ex_redirect_pc, output, 32: correct next PC.
- branch_count, output, CNT_W: resolved control-flow instructions.
- mispredict_count, output, CNT_W: mispredicts.

Behaviour:
- Reset: asynchronous, active-low (rst_n); clock clk.
  - All BTB valid bits = 0, every BHT counter = 2'b01 (weakly not-taken), GHR = 0, both perf counters = 0.
  - Outputs during and after reset: pred_taken = 0, pred_target = if_pc+4, ex_mispredict = 0 when ex_valid = 0.
  - BTB tag and target RAM contents are don't-care; they are gated by the valid bits.
- Index and tag:
  - btb_idx = pc[log2(BTB_ENTRIES)+1:2]; tag = pc[31:log2(BTB_ENTRIES)+2].
  - bht_idx = pc[log2(BHT_ENTRIES)+1:2], XORed with the zero-extended GHR when MODE = 1.
- Lookup (combinational, 0-cycle latency, reads the registered state):
  - hit = valid[btb_idx] && tag match.
  - pred_taken = hit && (entry is jump || bht[bht_idx][1]).
  - pred_target = pred_taken ? btb_target : if_pc+4.
- Resolution (combinational, qualified by ex_valid):
  - correct_pc = ex_taken ? ex_target : ex_pc+4.
  - ex_mispredict = ex_valid && (ex_pred_taken ? ex_pred_target != correct_pc : ex_taken).
  - ex_redirect_pc = correct_pc.
- Update (on the clk edge, only when ex_valid):
  - Branch: BHT counter at the bht_idx computed from ex_pc and the current GHR saturates up on taken, down on not-taken (11 and 00 stick). In MODE 1 the GHR shifts left with ex_taken inserted at the LSB.
  - Taken branch or jump: write BTB entry (valid = 1, tag, ex_target, is_jump flag). Direct-mapped; overwrites on conflict.
  - Not-taken branch: BTB entry left untouched.
  - Neither branch nor jump but ex_pred_taken = 1 (alias): invalidate that BTB entry; the mispredict fires with redirect = ex_pc+4.
  - Neither branch nor jump and no alias: no table or GHR change.
- GHR: trained non-speculatively at EX only, never at IF.
- Perf counters:
  - branch_count increments for each ex_valid branch or jump.
  - mispredict_count increments when ex_mispredict is asserted.
  - Both saturate at all-ones; no wrap.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update value; no bypass.
- Reset asserted mid-operation clears state immediately. Any in-flight EX update on that edge is discarded.

Decomposition:
- Shared package bp_pkg:
  - counter encodings SNT = 00, WNT = 01, WT = 10, ST = 11;
  - MODE_BIMODAL = 0, MODE_GSHARE = 1;
  - the BTB entry struct {valid, is_jump, tag, target}.
- One sub-module: bp_sat_counter, the 2-bit saturating next-state function. It is used by both the BHT and the perf-counter saturation logic, with width as a parameter.
- The top instantiates BTB and BHT arrays plus the GHR.

Test Plan:
1. Reset, MODE = 1: lookup if_pc = 0x40 → pred_taken = 0, pred_target = 0x44; branch_count = mispredict_count = 0.
2. Branch at 0x100 → 0x80, resolved taken twice with ex_pred_taken = 0:
   - First resolve: mispredict, redirect 0x80; counter 01→10.
   - Lookup of 0x100 with the GHR state reached after the second resolve → pred_taken = 1, pred_target = 0x80.
   - Expected counts: mispredict_count = 2, branch_count = 2.
3. JAL at 0x200 → 0x400 resolved once; next lookup 0x200 → pred_taken = 1, target 0x400. Resolve again with matching prediction → ex_mispredict = 0.
4. Aliasing, BTB_ENTRIES = 16: taken branch at 0x10 → 0x0 installed, then lookup 0x50 (same index, different tag) → pred_taken = 0. Then resolve a non-control instruction at 0x10 with ex_pred_taken = 1 → mispredict, redirect 0x14, entry invalidated.
5. Saturation, MODE = 0: branch at 0x300 resolved taken 5 times → counter holds 11. One not-taken resolve → counter 10 and lookup still predicts taken; second not-taken resolve → 01 and lookup predicts not-taken.
6. CNT_W = 4: 20 mispredicting branches → mispredict_count sticks at 15. Assert rst_n = 0 mid-stream → counters = 0 and pred_taken = 0 asynchronously.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the branch predictor
package bp_pkg;

    // 2-bit BHT counter encodings; bit 1 is the taken/not-taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Widest tag needed: 2-entry BTB leaves pc[31:3] as the tag.
    localparam int BTB_TAG_MAX_W = 29;

    typedef struct packed {
        logic                     valid;
        logic                     is_jump;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [31:0]              target;
    } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - saturating up/down counter next-state function
//
// Ports:
//   value      : current counter value
//   inc        : step up (sticks at all-ones)
//   dec        : step down (sticks at zero); inc and dec together hold
//   value_next : next counter value
module bp_sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] value,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value_next
);

    always_comb begin
        value_next = value;
        if (inc && !dec) begin
            if (value != {WIDTH{1'b1}}) value_next = value + WIDTH'(1);
        end else if (dec && !inc) begin
            if (value != '0) value_next = value - WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - dynamic branch predictor (tagged BTB + bimodal/gshare BHT)
//
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   if_pc                          : fetch PC looked up this cycle
//   pred_taken, pred_target        : combinational prediction for if_pc
//   ex_valid, ex_pc                : resolving instruction in EX
//   ex_is_branch, ex_is_jump       : conditional branch / JAL-JALR
//   ex_taken, ex_target            : resolved outcome
//   ex_pred_taken, ex_pred_target  : prediction that travelled with the instruction
//   ex_mispredict, ex_redirect_pc  : redirect request and correct next PC
//   branch_count, mispredict_count : saturating performance counters
module branch_predictor
    import bp_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int BHT_ENTRIES = 64,
    parameter int GHR_W       = 6,
    parameter int MODE        = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             ex_mispredict,
    output logic [31:0]      ex_redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

    // Valid bits carry reset; tag/target storage is plain RAM gated by them.
    logic [BTB_ENTRIES-1:0] btb_valid;
    btb_entry_t             btb_ram [BTB_ENTRIES];
    logic [1:0]             bht [BHT_ENTRIES];
    logic [GHR_W-1:0]       ghr;
    logic [CNT_W-1:0]       branch_cnt_q, branch_cnt_next;
    logic [CNT_W-1:0]       mispredict_cnt_q, mispredict_cnt_next;

    logic [BHT_IDX_W-1:0]     hist_term;
    logic [BTB_IDX_W-1:0]     if_btb_idx, ex_btb_idx;
    logic [BTB_TAG_MAX_W-1:0] if_tag, ex_tag;
    logic [BHT_IDX_W-1:0]     if_bht_idx, ex_bht_idx;
    btb_entry_t               btb_rd;
    logic                     if_hit;
    logic [31:0]              correct_pc;
    logic [1:0]               bht_next;
    logic                     bht_upd, btb_install, btb_kill, ctrl_resolved;

    // Bimodal ignores history; gshare folds the zero-extended GHR into the index.
    assign hist_term  = (MODE == MODE_GSHARE) ? BHT_IDX_W'(ghr) : '0;

    assign if_btb_idx = if_pc[BTB_IDX_W+1:2];
    assign if_tag     = BTB_TAG_MAX_W'(if_pc[31:BTB_IDX_W+2]);
    assign if_bht_idx = if_pc[BHT_IDX_W+1:2] ^ hist_term;
    assign ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
    assign ex_tag     = BTB_TAG_MAX_W'(ex_pc[31:BTB_IDX_W+2]);
    assign ex_bht_idx = ex_pc[BHT_IDX_W+1:2] ^ hist_term;

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        btb_rd       = btb_ram[if_btb_idx];
        btb_rd.valid = btb_valid[if_btb_idx];
    end

    assign if_hit      = btb_rd.valid && (btb_rd.tag == if_tag);
    assign pred_taken  = if_hit && (btb_rd.is_jump || bht[if_bht_idx][1]);
    assign pred_target = pred_taken ? btb_rd.target : if_pc + 32'd4;

    assign correct_pc     = ex_taken ? ex_target : ex_pc + 32'd4;
    assign ex_mispredict  = ex_valid && (ex_pred_taken ? (ex_pred_target != correct_pc) : ex_taken);
    assign ex_redirect_pc = correct_pc;

    assign bht_upd       = ex_valid && ex_is_branch;
    assign btb_install   = ex_valid && ((ex_is_branch && ex_taken) || ex_is_jump);
    // A non-control instruction predicted taken means the BTB entry aliased onto it.
    assign btb_kill      = ex_valid && !ex_is_branch && !ex_is_jump && ex_pred_taken;
    assign ctrl_resolved = ex_valid && (ex_is_branch || ex_is_jump);

    bp_sat_counter #(.WIDTH(2)) u_bht_sat (
        .value      (bht[ex_bht_idx]),
        .inc        (ex_taken),
        .dec        (!ex_taken),
        .value_next (bht_next)
    );

    bp_sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
        .value      (branch_cnt_q),
        .inc        (ctrl_resolved),
        .dec        (1'b0),
        .value_next (branch_cnt_next)
    );

    bp_sat_counter #(.WIDTH(CNT_W)) u_mispredict_cnt (
        .value      (mispredict_cnt_q),
        .inc        (ex_mispredict),
        .dec        (1'b0),
        .value_next (mispredict_cnt_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= WNT;
            ghr              <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (bht_upd) begin
                bht[ex_bht_idx] <= bht_next;
                // History is trained only with resolved outcomes, never at fetch.
                if (MODE == MODE_GSHARE) ghr <= GHR_W'({ghr, ex_taken});
            end
            if (btb_install)   btb_valid[ex_btb_idx] <= 1'b1;
            else if (btb_kill) btb_valid[ex_btb_idx] <= 1'b0;
            branch_cnt_q     <= branch_cnt_next;
            mispredict_cnt_q <= mispredict_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && btb_install) begin
            btb_ram[ex_btb_idx] <= '{valid: 1'b1, is_jump: ex_is_jump, tag: ex_tag, target: ex_target};
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor (gshare and bimodal instances)
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;

    logic        g_pred_taken, b_pred_taken, g_mis, b_mis;
    logic [31:0] g_pred_target, b_pred_target, g_redirect, b_redirect;
    logic [31:0] g_bc, g_mc;
    logic [3:0]  b_bc, b_mc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predictor #(.BTB_ENTRIES(16), .BHT_ENTRIES(64), .GHR_W(6), .MODE(1), .CNT_W(32)) dut_g (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(g_pred_taken), .pred_target(g_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ex_mispredict(g_mis), .ex_redirect_pc(g_redirect),
        .branch_count(g_bc), .mispredict_count(g_mc)
    );

    branch_predictor #(.BTB_ENTRIES(16), .BHT_ENTRIES(64), .GHR_W(6), .MODE(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(b_pred_taken), .pred_target(b_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ex_mispredict(b_mis), .ex_redirect_pc(b_redirect),
        .branch_count(b_bc), .mispredict_count(b_mc)
    );

    // Reference model: index 0 = bimodal (dut_b, 4-bit counters), 1 = gshare (dut_g, 32-bit counters).
    bit          m_btb_v   [16];
    bit          m_btb_j   [16];
    logic [31:0] m_btb_pc  [16];
    logic [31:0] m_btb_tgt [16];
    int          m_bht [2][64];
    int          m_ghr;
    longint      m_bc [2];
    longint      m_mc [2];
    longint      m_max [2] = '{15, 64'h0000_0000_FFFF_FFFF};

    function automatic int btb_slot(logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int bht_slot(int m, logic [31:0] pc);
        int base;
        base = int'((pc / 4) % 64);
        return (m == 1) ? (base ^ m_ghr) : base;
    endfunction

    function automatic bit model_pred(int m, logic [31:0] pc);
        int i;
        i = btb_slot(pc);
        if (!m_btb_v[i] || (m_btb_pc[i] / 64) != (pc / 64)) return 1'b0;
        return m_btb_j[i] || (m_bht[m][bht_slot(m, pc)] >= 2);
    endfunction

    function automatic logic [31:0] model_target(int m, logic [31:0] pc);
        return model_pred(m, pc) ? m_btb_tgt[btb_slot(pc)] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] model_correct();
        return ex_taken ? ex_target : ex_pc + 32'd4;
    endfunction

    function automatic bit model_mis();
        if (!ex_valid) return 1'b0;
        return ex_pred_taken ? (ex_pred_target != model_correct()) : ex_taken;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_btb_v[i] = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) m_bht[m][i] = 1;
            m_bc[m] = 0;
            m_mc[m] = 0;
        end
        m_ghr = 0;
    endfunction

    function automatic void model_update();
        int s;
        bit mis;
        if (!ex_valid) return;
        mis = model_mis();
        if (ex_is_branch) begin
            for (int m = 0; m < 2; m++) begin
                s = bht_slot(m, ex_pc);
                if (ex_taken) m_bht[m][s] = (m_bht[m][s] < 3) ? m_bht[m][s] + 1 : 3;
                else          m_bht[m][s] = (m_bht[m][s] > 0) ? m_bht[m][s] - 1 : 0;
            end
            m_ghr = ((m_ghr * 2) + int'(ex_taken)) % 64;
        end
        s = btb_slot(ex_pc);
        if ((ex_is_branch && ex_taken) || ex_is_jump) begin
            m_btb_v[s] = 1'b1; m_btb_j[s] = ex_is_jump; m_btb_pc[s] = ex_pc; m_btb_tgt[s] = ex_target;
        end else if (!ex_is_branch && !ex_is_jump && ex_pred_taken) begin
            m_btb_v[s] = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
            if ((ex_is_branch || ex_is_jump) && m_bc[m] < m_max[m]) m_bc[m]++;
            if (mis && m_mc[m] < m_max[m]) m_mc[m]++;
        end
    endfunction

    task automatic idle_ex();
        ex_valid = 1'b0; ex_pc = 32'h0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
        ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    endtask

    task automatic ex_op(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_pc = pc; ex_is_branch = br; ex_is_jump = jmp; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    // Inputs change just after a falling edge; the model follows the DUT across the rising edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_update();
        else       model_reset();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_ex();
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; idle_ex(); model_reset(); if_pc = 32'h40;
        #2;
        n_checks++; if (g_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %0h want 0", g_pred_taken); end
        n_checks++; if (g_pred_target !== 32'h44) begin n_fail++; $display("FAIL reset_pred_target: got %h want 00000044", g_pred_target); end
        n_checks++; if (g_bc !== 32'h0 || g_mc !== 32'h0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", g_bc, g_mc); end
        n_checks++; if (g_mis !== 1'b0 || b_mis !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict: got %0h/%0h want 0/0", g_mis, b_mis); end
        cycle();
        rst_n = 1'b1;
        cycle();
        #2;
        n_checks++; if (b_pred_taken !== 1'b0 || b_pred_target !== 32'h44) begin n_fail++; $display("FAIL post_reset_lookup: got %0h %h want 0 00000044", b_pred_taken, b_pred_target); end
        n_checks++; if (b_bc !== 4'h0 || b_mc !== 4'h0) begin n_fail++; $display("FAIL post_reset_counts: got %0d/%0d want 0/0", b_bc, b_mc); end
    endtask

    task automatic test_branch_train();
        apply_reset();
        if_pc = 32'h100;
        for (int k = 0; k < 2; k++) begin
            ex_op(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
            #2;
            n_checks++; if (g_mis !== 1'b1 || g_redirect !== 32'h80) begin n_fail++; $display("FAIL branch_resolve_%0d: got %0h %h want 1 00000080", k, g_mis, g_redirect); end
            cycle();
        end
        idle_ex();
        #2;
        n_checks++; if (b_pred_taken !== 1'b1 || b_pred_target !== 32'h80) begin n_fail++; $display("FAIL branch_lookup_bimodal: got %0h %h want 1 00000080", b_pred_taken, b_pred_target); end
        n_checks++; if (g_pred_taken !== model_pred(1, 32'h100) || g_pred_target !== model_target(1, 32'h100)) begin n_fail++; $display("FAIL branch_lookup_gshare: got %0h %h want %0h %h", g_pred_taken, g_pred_target, model_pred(1, 32'h100), model_target(1, 32'h100)); end
        n_checks++; if (g_bc !== 32'd2 || g_mc !== 32'd2) begin n_fail++; $display("FAIL branch_counts: got %0d/%0d want 2/2", g_bc, g_mc); end
    endtask

    task automatic test_jump();
        apply_reset();
        if_pc = 32'h200;
        ex_op(32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204);
        #2;
        n_checks++; if (g_mis !== 1'b1 || g_redirect !== 32'h400) begin n_fail++; $display("FAIL jump_first: got %0h %h want 1 00000400", g_mis, g_redirect); end
        cycle();
        idle_ex();
        #2;
        n_checks++; if (g_pred_taken !== 1'b1 || g_pred_target !== 32'h400 || b_pred_taken !== 1'b1) begin n_fail++; $display("FAIL jump_lookup: got %0h %h %0h want 1 00000400 1", g_pred_taken, g_pred_target, b_pred_taken); end
        ex_op(32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h400);
        #2;
        n_checks++; if (g_mis !== 1'b0 || b_redirect !== 32'h400) begin n_fail++; $display("FAIL jump_predicted: got %0h %h want 0 00000400", g_mis, b_redirect); end
        cycle();
    endtask

    task automatic test_alias();
        apply_reset();
        ex_op(32'h10, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h14);
        cycle();
        idle_ex();
        if_pc = 32'h50;
        #2;
        n_checks++; if (g_pred_taken !== 1'b0 || b_pred_taken !== 1'b0 || b_pred_target !== 32'h54) begin n_fail++; $display("FAIL alias_tag_miss: got %0h %0h %h want 0 0 00000054", g_pred_taken, b_pred_taken, b_pred_target); end
        if_pc = 32'h10;
        ex_op(32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        #2;
        n_checks++; if (g_mis !== 1'b1 || g_redirect !== 32'h14) begin n_fail++; $display("FAIL alias_mispredict: got %0h %h want 1 00000014", g_mis, g_redirect); end
        n_checks++; if (b_pred_taken !== 1'b1 || b_pred_target !== 32'h0) begin n_fail++; $display("FAIL alias_no_bypass: got %0h %h want 1 00000000", b_pred_taken, b_pred_target); end
        cycle();
        idle_ex();
        #2;
        n_checks++; if (b_pred_taken !== 1'b0 || b_pred_target !== 32'h14) begin n_fail++; $display("FAIL alias_invalidated: got %0h %h want 0 00000014", b_pred_taken, b_pred_target); end
    endtask

    task automatic test_saturation();
        apply_reset();
        if_pc = 32'h300;
        repeat (5) begin
            ex_op(32'h300, 1'b1, 1'b0, 1'b1, 32'h380, 1'b0, 32'h304);
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            ex_op(32'h300, 1'b1, 1'b0, 1'b0, 32'h380, 1'b1, 32'h380);
            cycle();
            idle_ex();
            #2;
            n_checks++;
            if (k == 0 && (b_pred_taken !== 1'b1 || b_pred_target !== 32'h380)) begin n_fail++; $display("FAIL sat_one_nt: got %0h %h want 1 00000380", b_pred_taken, b_pred_target); end
            if (k == 1 && (b_pred_taken !== 1'b0 || b_pred_target !== 32'h304)) begin n_fail++; $display("FAIL sat_two_nt: got %0h %h want 0 00000304", b_pred_taken, b_pred_target); end
        end
    endtask

    task automatic test_counter_sat_and_reset();
        apply_reset();
        if_pc = 32'h500;
        for (int k = 0; k < 20; k++) begin
            ex_op(32'h500, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 32'h504);
            cycle();
        end
        #2;
        n_checks++; if (b_mc !== 4'hF || b_bc !== 4'hF) begin n_fail++; $display("FAIL cnt_saturate: got %0d/%0d want 15/15", b_bc, b_mc); end
        n_checks++; if (g_mc !== 32'd20 || g_bc !== 32'd20) begin n_fail++; $display("FAIL cnt_wide: got %0d/%0d want 20/20", g_bc, g_mc); end
        n_checks++; if (b_pred_taken !== 1'b1) begin n_fail++; $display("FAIL cnt_pre_reset_pred: got %0h want 1", b_pred_taken); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (b_mc !== 4'h0 || g_mc !== 32'h0 || g_bc !== 32'h0) begin n_fail++; $display("FAIL async_reset_counts: got %0d/%0d/%0d want 0/0/0", b_mc, g_mc, g_bc); end
        n_checks++; if (b_pred_taken !== 1'b0 || g_pred_taken !== 1'b0) begin n_fail++; $display("FAIL async_reset_pred: got %0h/%0h want 0/0", b_pred_taken, g_pred_taken); end
        model_reset();
        cycle();
        rst_n = 1'b1;
        idle_ex();
        #2;
        n_checks++; if (b_pred_taken !== 1'b0 || b_bc !== 4'h0 || g_bc !== 32'h0) begin n_fail++; $display("FAIL reset_discards_update: got %0h %0d %0d want 0 0 0", b_pred_taken, b_bc, g_bc); end
    endtask

    task automatic test_random();
        logic [31:0] pool [8] = '{32'h100, 32'h140, 32'h104, 32'h500, 32'h1100, 32'h2c, 32'h80, 32'h3fc};
        int kind;
        logic [31:0] pc;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            pc   = pool[$urandom_range(0, 7)];
            kind = $urandom_range(0, 9);
            if (kind < 5)      ex_op(pc, 1'b1, 1'b0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 1'b0, 32'h0);
            else if (kind < 7) ex_op(pc, 1'b0, 1'b1, 1'b1, pool[$urandom_range(0, 7)], 1'b0, 32'h0);
            else               ex_op(pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            if ($urandom_range(0, 1) == 1) begin
                ex_pred_taken = model_pred(1, pc); ex_pred_target = model_target(1, pc);
            end else begin
                ex_pred_taken = 1'($urandom_range(0, 1)); ex_pred_target = pool[$urandom_range(0, 7)];
            end
            ex_valid = ($urandom_range(0, 7) != 0);
            if_pc = pool[$urandom_range(0, 7)];
            #2;
            n_checks++; if (g_pred_taken !== model_pred(1, if_pc) || g_pred_target !== model_target(1, if_pc)) begin n_fail++; $display("FAIL rnd_gshare_pred @%0d: got %0h %h want %0h %h", n, g_pred_taken, g_pred_target, model_pred(1, if_pc), model_target(1, if_pc)); end
            n_checks++; if (b_pred_taken !== model_pred(0, if_pc) || b_pred_target !== model_target(0, if_pc)) begin n_fail++; $display("FAIL rnd_bimodal_pred @%0d: got %0h %h want %0h %h", n, b_pred_taken, b_pred_target, model_pred(0, if_pc), model_target(0, if_pc)); end
            n_checks++; if (g_mis !== model_mis() || g_redirect !== model_correct()) begin n_fail++; $display("FAIL rnd_resolve @%0d: got %0h %h want %0h %h", n, g_mis, g_redirect, model_mis(), model_correct()); end
            n_checks++; if (g_bc !== 32'(m_bc[1]) || g_mc !== 32'(m_mc[1])) begin n_fail++; $display("FAIL rnd_counts_g @%0d: got %0d/%0d want %0d/%0d", n, g_bc, g_mc, m_bc[1], m_mc[1]); end
            n_checks++; if (b_bc !== 4'(m_bc[0]) || b_mc !== 4'(m_mc[0])) begin n_fail++; $display("FAIL rnd_counts_b @%0d: got %0d/%0d want %0d/%0d", n, b_bc, b_mc, m_bc[0], m_mc[0]); end
            cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h0;
        idle_ex();
        model_reset();
        test_reset();
        test_branch_train();
        test_jump();
        test_alias();
        test_saturation();
        test_counter_sat_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
